// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared SHA-256 word type, sigma/choice functions and round constants
package sha256_pkg;

  localparam int WORD_W = 32;
  typedef logic [WORD_W-1:0] word_t;

  // Message-schedule controller states
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } sched_state_t;

  function automatic word_t rotr(input word_t x, input int n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  // Schedule expansion helpers (lower-case sigma)
  function automatic word_t sigma0_small(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t sigma1_small(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Compression-round helpers (upper-case Sigma, choice, majority)
  function automatic word_t sigma0_big(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t sigma1_big(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t ch(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic word_t maj(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  // Round constants, indexed by the round number carried alongside W_t
  localparam word_t K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

endpackage

// File: rtl/sha256_msg_schedule_if.sv
// rtl/sha256_msg_schedule_if.sv - block-in / schedule-word-out handshake bundle
interface sha256_msg_schedule_if
  import sha256_pkg::*;
#(
  parameter int IDX_W = 6
);

  logic             blk_valid;
  logic             blk_ready;
  logic [511:0]     blk_data;
  word_t            w_out;
  logic [IDX_W-1:0] w_idx;
  logic             w_valid;
  logic             w_ready;
  logic             w_last;

  // Source of blocks and sink of schedule words
  modport master (
    output blk_valid, blk_data, w_ready,
    input  blk_ready, w_out, w_idx, w_valid, w_last
  );

  // Schedule generator side
  modport slave (
    input  blk_valid, blk_data, w_ready,
    output blk_ready, w_out, w_idx, w_valid, w_last
  );

endinterface

// File: rtl/sha256_msg_schedule.sv
// rtl/sha256_msg_schedule.sv - 16-word sliding window producing W_0..W_{NUM_ROUNDS-1}
module sha256_msg_schedule
  import sha256_pkg::*;
#(
  parameter int NUM_ROUNDS = 64,
  parameter int IDX_W      = 6
) (
  input logic                  clk,
  input logic                  rst,
  sha256_msg_schedule_if.slave bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS - 1);

  sched_state_t     r_state;
  sched_state_t     w_state_nxt;
  word_t            r_window [16];
  logic [IDX_W-1:0] r_t;

  logic  w_load;
  logic  w_xfer;
  logic  w_end;
  logic  w_advance;
  word_t w_new_word;

  // Block is taken only while idle; words move only while running
  assign w_load     = (r_state == ST_IDLE) && bus.blk_valid;
  assign w_xfer     = (r_state == ST_RUN) && bus.w_ready;
  assign w_end      = w_xfer && (r_t == LAST_IDX);
  assign w_advance  = w_xfer && (r_t != LAST_IDX);

  // Next schedule word enters at the tail as the head word leaves
  assign w_new_word = sigma1_small(r_window[14]) + r_window[9]
                    + sigma0_small(r_window[1]) + r_window[0];

  // All outputs decode registers only
  assign bus.blk_ready = (r_state == ST_IDLE);
  assign bus.w_valid   = (r_state == ST_RUN);
  assign bus.w_out     = r_window[0];
  assign bus.w_idx     = r_t;
  assign bus.w_last    = (r_state == ST_RUN) && (r_t == LAST_IDX);

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state: load a block, then run until the last word is accepted
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (bus.blk_valid) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_end)         w_state_nxt = ST_IDLE;
      default:                    w_state_nxt = ST_IDLE;
    endcase
  end

  // Window: parallel load of the block, shift-and-append on each transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) r_window[i] <= '0;
    end else if (w_load) begin
      for (int i = 0; i < 16; i++) r_window[i] <= bus.blk_data[511 - 32*i -: 32];
    end else if (w_advance) begin
      for (int i = 0; i < 15; i++) r_window[i] <= r_window[i+1];
      r_window[15] <= w_new_word;
    end
  end

  // Round index; cleared on load and after the final word so idle shows 0
  always_ff @(posedge clk) begin
    if (rst)            r_t <= '0;
    else if (w_load)    r_t <= '0;
    else if (w_end)     r_t <= '0;
    else if (w_advance) r_t <= r_t + IDX_W'(1);
  end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// tb/tb_sha256_msg_schedule.sv - directed and randomized checks of the schedule stream
module tb_sha256_msg_schedule;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  sha256_msg_schedule_if #(.IDX_W(6)) bus ();

  sha256_msg_schedule #(.NUM_ROUNDS(64), .IDX_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks      = 0;
  int failures    = 0;
  int lasts_seen  = 0;
  int blocks_done = 0;

  logic [31:0] ref_w   [64];
  logic [31:0] obs_w   [64];
  logic [31:0] saved_w [64];

  logic [511:0] abc_blk;
  logic [511:0] alt_blk;
  logic [511:0] rnd_blk;
  int           waited;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference: full 64-word expansion by the textbook recurrence
  task automatic build_ref(input logic [511:0] b);
    for (int t = 0; t < 16; t++) ref_w[t] = b[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      logic [31:0] s0, s1;
      s0 = ror(ref_w[t-15], 7) ^ ror(ref_w[t-15], 18) ^ (ref_w[t-15] >> 3);
      s1 = ror(ref_w[t-2], 17) ^ ror(ref_w[t-2], 19) ^ (ref_w[t-2] >> 10);
      ref_w[t] = s1 + ref_w[t-7] + s0 + ref_w[t-16];
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: ready always; 1: stall 3 cycles at t=20; 2: random ready;
  // 3: ready always while a different block is held on blk_* during the run
  task automatic run_block(input logic [511:0] blk, input int mode,
                           input logic [511:0] other, output int n_wait);
    int t, stall, cyc;
    logic rdy;
    build_ref(blk);
    bus.blk_data  = blk;
    bus.blk_valid = 1'b1;
    n_wait = 0;
    while (!bus.blk_ready && n_wait < 200) begin
      tick();
      n_wait++;
    end
    check("blk_ready_before_load", 64'(bus.blk_ready), 64'(1));
    tick();
    if (mode == 3) bus.blk_data = other;
    else           bus.blk_valid = 1'b0;
    t = 0; stall = 0; cyc = 0;
    while (t < 64 && cyc < 2000) begin
      case (mode)
        1:       rdy = !(t == 20 && stall < 3);
        2:       rdy = ($urandom_range(0, 3) != 0);
        default: rdy = 1'b1;
      endcase
      bus.w_ready = rdy;
      check("w_valid", 64'(bus.w_valid), 64'(1));
      check("w_out",   64'(bus.w_out),   64'(ref_w[t]));
      check("w_idx",   64'(bus.w_idx),   64'(t));
      check("w_last",  64'(bus.w_last),  64'(t == 63));
      if (mode == 3) check("blk_ready_in_run", 64'(bus.blk_ready), 64'(0));
      if (rdy) begin
        obs_w[t] = bus.w_out;
        if (bus.w_last) lasts_seen++;
      end
      tick();
      cyc++;
      if (rdy) t++;
      else if (t == 20) stall++;
    end
    check("stream_complete", 64'(t), 64'(64));
    if (mode == 1) check("stall_cycles", 64'(stall), 64'(3));
    check("w_valid_after_last",   64'(bus.w_valid),   64'(0));
    check("blk_ready_after_last", 64'(bus.blk_ready), 64'(1));
    blocks_done++;
  endtask

  initial begin
    bus.blk_valid = 1'b0;
    bus.blk_data  = '0;
    bus.w_ready   = 1'b0;
    abc_blk = {32'h61626380, 448'h0, 32'h00000018};
    for (int j = 0; j < 16; j++) alt_blk[511 - 32*j -: 32] = 32'hA5A50000 + 32'(j);

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    check("rst_blk_ready", 64'(bus.blk_ready), 64'(1));
    check("rst_w_valid",   64'(bus.w_valid),   64'(0));
    check("rst_w_last",    64'(bus.w_last),    64'(0));
    check("rst_w_out",     64'(bus.w_out),     64'(0));
    check("rst_w_idx",     64'(bus.w_idx),     64'(0));
    rst = 1'b0;
    tick();

    // "abc" block, no stalls, against known schedule words
    run_block(abc_blk, 0, '0, waited);
    check("abc_w0",  64'(obs_w[0]),  64'(32'h61626380));
    check("abc_w14", 64'(obs_w[14]), 64'(32'h00000000));
    check("abc_w15", 64'(obs_w[15]), 64'(32'h00000018));
    check("abc_w16", 64'(obs_w[16]), 64'(32'h61626380));
    check("abc_w17", 64'(obs_w[17]), 64'(32'h000F0000));
    check("abc_w63", 64'(obs_w[63]), 64'(32'h12B1EDEB));
    for (int i = 0; i < 64; i++) saved_w[i] = obs_w[i];
    tick();

    // Stall at t=20; sequence must match the unstalled run
    run_block(abc_blk, 1, '0, waited);
    for (int i = 0; i < 64; i++) check("stall_vs_nostall", 64'(obs_w[i]), 64'(saved_w[i]));

    // Held blk_valid with another block during run, then back-to-back capture
    run_block(abc_blk, 3, alt_blk, waited);
    check("held_blk_w63", 64'(obs_w[63]), 64'(32'h12B1EDEB));
    run_block(alt_blk, 0, '0, waited);
    check("b2b_no_wait", 64'(waited), 64'(0));

    // Reset in the middle of a block at t=30
    build_ref(abc_blk);
    bus.blk_data  = abc_blk;
    bus.blk_valid = 1'b1;
    check("mid_rst_ready", 64'(bus.blk_ready), 64'(1));
    tick();
    bus.blk_valid = 1'b0;
    bus.w_ready   = 1'b1;
    for (int k = 0; k < 30; k++) begin
      check("mid_rst_w_out", 64'(bus.w_out), 64'(ref_w[k]));
      if (bus.w_last) lasts_seen++;
      tick();
    end
    check("mid_rst_idx30", 64'(bus.w_idx), 64'(30));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("after_rst_w_valid",   64'(bus.w_valid),   64'(0));
    check("after_rst_blk_ready", 64'(bus.blk_ready), 64'(1));
    check("after_rst_w_idx",     64'(bus.w_idx),     64'(0));
    check("after_rst_w_last",    64'(bus.w_last),    64'(0));
    run_block(abc_blk, 0, '0, waited);
    check("after_rst_abc_w0", 64'(obs_w[0]), 64'(32'h61626380));

    // Random blocks with random downstream backpressure
    for (int n = 0; n < 200; n++) begin
      for (int j = 0; j < 16; j++) rnd_blk[511 - 32*j -: 32] = $urandom;
      run_block(rnd_blk, 2, '0, waited);
      if ($urandom_range(0, 1) == 1) tick();
    end

    check("w_last_count", 64'(lasts_seen), 64'(blocks_done));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
